data_memory_arbiter: RTL and testbench

//  Shares the single-port data memory between NUM_REQ requesters (CPU load/store unit, DMA/loader, ...).

---
 rtl/data_memory_arbiter_pkg.sv | 18 +
 rtl/data_memory_arbiter_if.sv | 37 +++
 rtl/data_memory_arbiter_rr_arbiter.sv | 33 +++
 rtl/data_memory_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package mem_arb_pkg;

  // Access sequencer states: wait for a request, drive the memory, hold the response.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam int unsigned MEM_DEPTH_DEFAULT = 16500;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester request/response handshakes plus the single-port memory bus.
interface data_memory_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         mem_rdata;

  // Requesters and the memory array together form the master side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  // The arbiter sits on the slave side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester after last_grant wins.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan NUM_REQ candidates starting one past the previous winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_REQ requesters.
// One access in flight at a time: accept (IDLE) -> memory access (ISSUE) -> response (RESP).
// Optional address bounds check enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module data_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input logic                 Clk,
  input logic                 Reset,
  data_memory_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic               oob;

  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_read;
  logic               mem_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Out-of-range address of the latched request; constant 0 when the check is disabled.
  assign oob = BOUNDS_EN && (64'(addr_q) >= 64'(MEM_DEPTH));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/memory strobes; write and grant gated off during Reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!Reset) begin
          req_ready = grant;
          accept    = |grant;
        end
        if (accept) begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (!oob) begin
          mem_read  = ~write_q;
          mem_write = write_q & ~Reset;
        end
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Request latch on accept and response capture at the end of the memory cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        write_q      <= bus.req_write[grant_idx];
        addr_q       <= bus.req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
        wdata_q      <= bus.req_wdata[32'(grant_idx) * DATA_W +: DATA_W];
      end
      if (state_q == ARB_ISSUE) begin
        rdata_q <= (write_q || oob) ? '0 : bus.mem_rdata;
        err_q   <= oob;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural asynchronous-read memory.
module tb_data_memory_arbiter;

  localparam int unsigned DEPTH = 16500;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  data_memory_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  data_memory_arbiter #(
    .NUM_REQ   (2),
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:DEPTH-1];

  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[14:0]] : 32'h0;

  always @(posedge Clk) begin
    if (bus.mem_write === 1'b1 && bus.mem_addr < 32'(DEPTH)) begin
      mem[bus.mem_addr[14:0]] <= bus.mem_wdata;
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge Clk) begin
    if (bus.mem_read === 1'b1) rd_cnt++;
    if (bus.mem_write === 1'b1) wr_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rd_snap;
    int wr_snap;
    logic [1:0]  onehot;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rd;

    Reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = '0;
    mem[0]   <= 32'h0;
    mem[5]   <= 32'hDEADBEEF;
    mem[7]   <= 32'h0000_0777;
    mem[10]  <= 32'h0000_00A0;
    mem[20]  <= 32'h0000_00B0;
    mem[100] <= 32'h0;

    // Reset state, with a request pending that must not be granted.
    @(negedge Clk);
    bus.req_valid = 2'b01;
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    bus.req_valid = '0;

    // Single read of address 5 by requester 0.
    bus.req_valid = 2'b01;
    bus.req_addr[31:0] = 32'd5;
    #1;
    check("t1_req_ready", bus.req_ready, 2'b01);
    @(negedge Clk);
    bus.req_valid = '0;
    #1;
    check("t1_mem_read", bus.mem_read, 1'b1);
    check("t1_mem_write", bus.mem_write, 1'b0);
    check("t1_mem_addr", bus.mem_addr, 32'd5);
    check("t1_rsp_valid_early", bus.rsp_valid, 2'b00);
    @(negedge Clk);
    bus.rsp_ready = 2'b01;
    #1;
    check("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check("t1_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    check("t1_rsp_err", bus.rsp_err, 1'b0);
    check("t1_mem_read_off", bus.mem_read, 1'b0);
    @(negedge Clk);
    bus.rsp_ready = '0;
    #1;
    check("t1_rsp_done", bus.rsp_valid, 2'b00);

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'd20, 32'd10};
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      onehot   = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'd10 : 32'd20;
      exp_data = (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0;
      #1;
      check($sformatf("t2_grant%0d", k), bus.req_ready, onehot);
      @(negedge Clk);
      #1;
      check($sformatf("t2_mem_addr%0d", k), bus.mem_addr, exp_addr);
      check($sformatf("t2_ready_busy%0d", k), bus.req_ready, 2'b00);
      @(negedge Clk);
      #1;
      check($sformatf("t2_rsp_valid%0d", k), bus.rsp_valid, onehot);
      check($sformatf("t2_rsp_rdata%0d", k), bus.rsp_rdata, exp_data);
      @(negedge Clk);
    end
    bus.req_valid = '0;

    // Write then read address 100 from requester 1.
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr[63:32]  = 32'd100;
    bus.req_wdata[63:32] = 32'h12345678;
    #1;
    check("t3_w_grant", bus.req_ready, 2'b10);
    @(negedge Clk);
    bus.req_valid = '0;
    #1;
    check("t3_mem_write", bus.mem_write, 1'b1);
    check("t3_mem_read", bus.mem_read, 1'b0);
    check("t3_mem_addr", bus.mem_addr, 32'd100);
    check("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge Clk);
    #1;
    check("t3_w_rsp_valid", bus.rsp_valid, 2'b10);
    check("t3_w_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge Clk);
    bus.req_valid = 2'b10;
    bus.req_write = 2'b00;
    #1;
    check("t3_r_grant", bus.req_ready, 2'b10);
    @(negedge Clk);
    bus.req_valid = '0;
    #1;
    check("t3_r_mem_read", bus.mem_read, 1'b1);
    @(negedge Clk);
    #1;
    check("t3_r_rsp_valid", bus.rsp_valid, 2'b10);
    check("t3_r_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    @(negedge Clk);

    // Response backpressure on requester 0 while requester 1 waits.
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b01;
    bus.req_addr[31:0] = 32'd5;
    #1;
    check("t4_grant", bus.req_ready, 2'b01);
    @(negedge Clk);
    bus.req_valid = 2'b10;
    bus.req_addr[63:32] = 32'd20;
    #1;
    check("t4_mem_read", bus.mem_read, 1'b1);
    @(negedge Clk);
    rd_snap = rd_cnt;
    wr_snap = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_hold_valid%0d", i), bus.rsp_valid, 2'b01);
      check($sformatf("t4_hold_rdata%0d", i), bus.rsp_rdata, 32'hDEADBEEF);
      check($sformatf("t4_hold_ready%0d", i), bus.req_ready, 2'b00);
      check($sformatf("t4_hold_mem%0d", i), {bus.mem_read, bus.mem_write}, 2'b00);
      @(negedge Clk);
    end
    bus.rsp_ready = 2'b01;
    bus.req_valid = '0;
    #1;
    check("t4_release_valid", bus.rsp_valid, 2'b01);
    @(negedge Clk);
    #1;
    check("t4_after_valid", bus.rsp_valid, 2'b00);
    check("t4_no_reads", rd_cnt - rd_snap, 0);
    check("t4_no_writes", wr_cnt - wr_snap, 0);

    // Reset during the memory cycle of a write to address 7.
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr[31:0]  = 32'd7;
    bus.req_wdata[31:0] = 32'h0000_0BAD;
    wr_snap = wr_cnt;
    #1;
    check("t5_grant", bus.req_ready, 2'b01);
    @(negedge Clk);
    Reset = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    #1;
    check("t5_write_gated", bus.mem_write, 1'b0);
    check("t5_issue_addr", bus.mem_addr, 32'd7);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("t5_mem7", mem[7], 32'h0000_0777);
    check("t5_no_writes", wr_cnt - wr_snap, 0);
    check("t5_rsp_valid", bus.rsp_valid, 2'b00);
    check("t5_req_ready", bus.req_ready, 2'b00);
    check("t5_mem_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    check("t5_mem_addr", bus.mem_addr, 32'h0);
    check("t5_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("t5_rsp_err", bus.rsp_err, 1'b0);

    // Read just past the end of memory.
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    exp_err = 1'b1;
    exp_rd  = 0;
`else
    exp_err = 1'b0;
    exp_rd  = 1;
`endif
    bus.req_valid = 2'b01;
    bus.req_addr[31:0] = 32'd16500;
    rd_snap = rd_cnt;
    #1;
    check("t6_grant", bus.req_ready, 2'b01);
    @(negedge Clk);
    bus.req_valid = '0;
    #1;
    check("t6_mem_read", bus.mem_read, exp_rd[0]);
    check("t6_mem_addr", bus.mem_addr, 32'd16500);
    @(negedge Clk);
    #1;
    check("t6_rsp_valid", bus.rsp_valid, 2'b01);
    check("t6_rsp_err", bus.rsp_err, exp_err);
    check("t6_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge Clk);
    #1;
    check("t6_read_count", rd_cnt - rd_snap, exp_rd);
    check("t6_rsp_done", bus.rsp_valid, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
